// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants for the multi-cycle MIPS-subset controller.
//   ALU op codes, opcode/funct encodings, FSM state codes, datapath select
//   codes and the instruction-class bundle produced by mc_decode.
package mc_ctrl_pkg;

  localparam logic [2:0] ALU_ADD           = 3'd0;
  localparam logic [2:0] ALU_SUB           = 3'd1;
  localparam logic [2:0] ALU_OR            = 3'd2;
  localparam logic [2:0] ALU_SHIFT_LEFT_16 = 3'd3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_NOP  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [1:0] NPC_PC4    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_JR     = 2'd3;

  localparam logic [1:0] RDST_RT = 2'd0;
  localparam logic [1:0] RDST_RD = 2'd1;
  localparam logic [1:0] RDST_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_DM  = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  // One-hot instruction class; all-zero means unsupported encoding.
  typedef struct packed {
    logic addu;
    logic subu;
    logic nop;
    logic jr;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
  } iclass_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_decode: combinational opcode/funct classifier.
//   op_i      : IR[31:26]
//   funct_i   : IR[5:0] (only meaningful for R-type)
//   cls_o     : one-hot instruction class
//   illegal_o : 1 when the encoding is not supported
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output iclass_t    cls_o,
  output logic       illegal_o
);

  always_comb begin
    cls_o = '0;
    unique case (op_i)
      OP_RTYPE: begin
        unique case (funct_i)
          FN_ADDU: cls_o.addu = 1'b1;
          FN_SUBU: cls_o.subu = 1'b1;
          FN_NOP:  cls_o.nop  = 1'b1;
          FN_JR:   cls_o.jr   = 1'b1;
          default: ;
        endcase
      end
      OP_ORI:  cls_o.ori = 1'b1;
      OP_LUI:  cls_o.lui = 1'b1;
      OP_LW:   cls_o.lw  = 1'b1;
      OP_SW:   cls_o.sw  = 1'b1;
      OP_BEQ:  cls_o.beq = 1'b1;
      OP_J:    cls_o.j   = 1'b1;
      OP_JAL:  cls_o.jal = 1'b1;
      default: ;
    endcase
    illegal_o = (cls_o == '0);
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller (FETCH/DECODE/EXEC/MEM/WB).
//   clk, reset (sync, active-high), op/funct from IR, zero from ALU.
//   Outputs: pc_we, npc_op, ir_we, reg_we, reg_dst, wd_sel, ext_op, alu_src,
//   alu_ctrl, mem_we, illegal (pulse), retire (pulse), retired (count).
//   Optional macro MC_CTRL_MEM_READY_EN adds input mem_ready, which stalls
//   S_FETCH and S_MEM until memory is ready.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
`ifdef MC_CTRL_MEM_READY_EN
  input  logic             mem_ready,
`endif
  output logic             pc_we,
  output logic [1:0]       npc_op,
  output logic             ir_we,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             ext_op,
  output logic             alu_src,
  output logic [2:0]       alu_ctrl,
  output logic             mem_we,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  iclass_t          cls;
  logic             dec_illegal;
  logic             ready;

`ifdef MC_CTRL_MEM_READY_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif

  mc_decode u_decode (
    .op_i      (op),
    .funct_i   (funct),
    .cls_o     (cls),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    state_d  = S_FETCH;
    pc_we    = 1'b0;
    npc_op   = NPC_PC4;
    ir_we    = 1'b0;
    reg_we   = 1'b0;
    reg_dst  = RDST_RT;
    wd_sel   = WD_ALU;
    ext_op   = 1'b0;
    alu_src  = 1'b0;
    alu_ctrl = ALU_ADD;
    mem_we   = 1'b0;
    illegal  = 1'b0;
    retire   = 1'b0;

    // ALU settings are driven identically in EXEC, MEM and WB so the ALU
    // result stays valid through write-back without a result register.
    if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
      if (cls.subu || cls.beq) alu_ctrl = ALU_SUB;
      else if (cls.ori)        alu_ctrl = ALU_OR;
      else if (cls.lui)        alu_ctrl = ALU_SHIFT_LEFT_16;
      alu_src = cls.ori || cls.lui || cls.lw || cls.sw;
      ext_op  = cls.lw || cls.sw || cls.beq;
    end

    case (state_q)
      S_FETCH: begin
        if (ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (cls.j || cls.jal) begin
          pc_we  = 1'b1;
          npc_op = NPC_JUMP;
          retire = 1'b1;
          if (cls.jal) begin
            reg_we  = 1'b1;
            reg_dst = RDST_RA;
            wd_sel  = WD_PC;
          end
        end else if (cls.jr) begin
          pc_we  = 1'b1;
          npc_op = NPC_JR;
          retire = 1'b1;
        end else if (cls.nop) begin
          retire = 1'b1;
        end else if (dec_illegal) begin
          illegal = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cls.beq) begin
          pc_we  = zero;
          npc_op = NPC_BRANCH;
          retire = 1'b1;
        end else if (cls.lw || cls.sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (!ready) begin
          state_d = S_MEM;
        end else if (cls.sw) begin
          mem_we = 1'b1;
          retire = 1'b1;
        end else if (cls.lw) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        reg_dst = (cls.addu || cls.subu) ? RDST_RD : RDST_RT;
        wd_sel  = cls.lw ? WD_DM : WD_ALU;
      end
      default: ;
    endcase

    // Reset suppresses every side effect in the same cycle, so an
    // interrupted instruction leaves no partial writes behind.
    if (reset) begin
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      reg_we  = 1'b0;
      mem_we  = 1'b0;
      illegal = 1'b0;
      retire  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign retired = retired_q;

endmodule
